// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch compare codes
// and the control state machine states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } br_cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_alu.sv
// Single-cycle combinational ALU; ALU_MUL and unknown codes yield zero here.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (ctl)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << shamt;
      ALU_SRL:   y = a >> shamt;
      ALU_SRA:   y = XLEN'($signed(a) >>> shamt);
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over XLEN steps,
// keeping only the low XLEN bits of the product.
module exec_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] product
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] acc_reg, mcand_reg, mplier_reg, acc_next;
  logic [SW-1:0]   cnt_reg;
  logic            busy_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last     = busy_reg && (cnt_reg == SW'(XLEN-1));
  // The final step's sum is exposed combinationally so the top can capture it
  // on the same edge that retires the last iteration.
  assign product  = acc_next;
  assign busy     = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (flush) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= {mcand_reg[XLEN-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
      cnt_reg    <= cnt_reg + SW'(1);
      if (last) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Pipelined execute stage: ALU, branch resolution and address generation with
// valid/ready handshakes and an optional multi-cycle multiplier.
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] reg1_data,
  input  logic [XLEN-1:0] reg2_data,
  input  logic [3:0]      alu_ctl,
  input  logic [2:0]      br_cond,
  input  logic            branch_uc,
  input  logic            branch_c,
  input  logic            branch_relative,
  input  logic            alu_pc,
  input  logic            alu_src,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            reg_write_in,
  input  logic            writef_in,
  input  logic [REGW-1:0] write_reg_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            reg_write_out,
  output logic            writef_out,
  output logic [REGW-1:0] write_reg_out,
  output logic            branch,
  output logic [XLEN-1:0] branch_addr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] reg_write_data,
  output logic            busy
);

  localparam int BW = 4*XLEN + 4 + 3 + 9 + REGW;

  state_e state_reg, state_next;
  logic   run_reg;
  logic [BW-1:0] in_bundle, hold_reg, cur;

  logic [XLEN-1:0] c_pc, c_imm, c_r1, c_r2;
  logic [3:0]      c_ctl;
  logic [2:0]      c_cond;
  logic            c_buc, c_bc, c_brel, c_apc, c_asrc, c_mr, c_mw, c_rw, c_wf;
  logic [REGW-1:0] c_wreg;

  logic [XLEN-1:0] src1, src2, alu_y, alu_out, mul_product, baddr_w, rwd_w;
  logic            mul_op, accept, mul_start, mul_busy, mul_last, cond, load_out;

  logic            out_valid_reg, branch_reg;
  logic            mem_read_reg, mem_write_reg, reg_write_reg, writef_reg;
  logic [REGW-1:0] write_reg_reg;
  logic [XLEN-1:0] branch_addr_reg, mem_addr_reg, mem_write_data_reg, reg_write_data_reg;

  assign in_bundle = {pc, imm, reg1_data, reg2_data, alu_ctl, br_cond,
                      branch_uc, branch_c, branch_relative, alu_pc, alu_src,
                      mem_read_in, mem_write_in, reg_write_in, writef_in, write_reg_in};

  // A multiply works from its latched fields; everything else from the live inputs.
  assign cur = (state_reg == ST_MUL) ? hold_reg : in_bundle;
  assign {c_pc, c_imm, c_r1, c_r2, c_ctl, c_cond, c_buc, c_bc, c_brel, c_apc, c_asrc,
          c_mr, c_mw, c_rw, c_wf, c_wreg} = cur;

  assign src1      = c_apc  ? c_pc  : c_r1;
  assign src2      = c_asrc ? c_imm : c_r2;
  assign mul_op    = (MUL_EN != 0) && (alu_ctl == ALU_MUL);
  assign in_ready  = run_reg && (state_reg == ST_IDLE) && !flush && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = (state_reg == ST_MUL) && !mul_busy && !flush;
  assign load_out  = (accept && !mul_op) || mul_last;

  exec_alu #(.XLEN(XLEN)) u_alu (.ctl(c_ctl), .a(src1), .b(src2), .y(alu_y));

  generate
    if (MUL_EN != 0) begin : g_mul
      exec_mul #(.XLEN(XLEN)) u_mul (
        .clk(clk), .rst(rst), .flush(flush), .start(mul_start),
        .a(src1), .b(src2), .busy(mul_busy), .last(mul_last), .product(mul_product)
      );
    end else begin : g_nomul
      assign mul_busy    = 1'b0;
      assign mul_last    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  assign alu_out = (state_reg == ST_MUL) ? mul_product : alu_y;

  always_comb begin
    cond = 1'b0;
    case (c_cond)
      BR_EQ:   cond = (c_r1 == c_r2);
      BR_NE:   cond = (c_r1 != c_r2);
      BR_LT:   cond = ($signed(c_r1) <  $signed(c_r2));
      BR_GE:   cond = ($signed(c_r1) >= $signed(c_r2));
      BR_LTU:  cond = (c_r1 <  c_r2);
      BR_GEU:  cond = (c_r1 >= c_r2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    baddr_w = {alu_out[XLEN-1:1], 1'b0};
    if (c_brel && c_buc)  baddr_w = c_pc + alu_out;
    else if (c_brel)      baddr_w = c_pc + c_imm;
  end

  assign rwd_w = c_buc ? (c_pc + XLEN'(4)) : alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept && mul_op) state_next = ST_MUL;
        ST_MUL:  if (mul_last)         state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg  <= 1'b0;
      hold_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      if (accept && mul_op) hold_reg <= in_bundle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg      <= 1'b0;
      branch_reg         <= 1'b0;
      branch_addr_reg    <= '0;
      mem_addr_reg       <= '0;
      mem_write_data_reg <= '0;
      reg_write_data_reg <= '0;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      reg_write_reg      <= 1'b0;
      writef_reg         <= 1'b0;
      write_reg_reg      <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (load_out) begin
      out_valid_reg      <= 1'b1;
      branch_reg         <= c_buc || (c_bc && cond);
      branch_addr_reg    <= baddr_w;
      mem_addr_reg       <= alu_out;
      mem_write_data_reg <= c_r2;
      reg_write_data_reg <= rwd_w;
      mem_read_reg       <= c_mr;
      mem_write_reg      <= c_mw;
      reg_write_reg      <= c_rw;
      writef_reg         <= c_wf;
      write_reg_reg      <= c_wreg;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid      = out_valid_reg;
  assign branch         = branch_reg;
  assign branch_addr    = branch_addr_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_write_data = mem_write_data_reg;
  assign reg_write_data = reg_write_data_reg;
  assign mem_read_out   = mem_read_reg;
  assign mem_write_out  = mem_write_reg;
  assign reg_write_out  = reg_write_reg;
  assign writef_out     = writef_reg;
  assign write_reg_out  = write_reg_reg;
  assign busy           = mul_busy;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: a spec-level model predicts every retired op,
// plus directed checks on handshake, multiplier timing, flush and reset.
module tb_exec_unit;
  import exec_pkg::*;

  typedef struct packed {
    logic [31:0] pc, imm, r1, r2;
    logic [3:0]  ctl;
    logic [2:0]  cond;
    logic buc, bc, brel, apc, asrc, mr, mw, rw, wf;
    logic [4:0]  wreg;
  } op_t;

  typedef struct packed {
    logic        branch;
    logic [31:0] baddr, maddr, mwd, rwd;
    logic mr, mw, rw, wf;
    logic [4:0]  wreg;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] pc = '0, imm = '0, reg1_data = '0, reg2_data = '0;
  logic [3:0]  alu_ctl = '0;
  logic [2:0]  br_cond = '0;
  logic branch_uc = 0, branch_c = 0, branch_relative = 0, alu_pc = 0, alu_src = 0;
  logic mem_read_in = 0, mem_write_in = 0, reg_write_in = 0, writef_in = 0;
  logic [4:0]  write_reg_in = '0;
  logic in_ready, out_valid, mem_read_out, mem_write_out, reg_write_out, writef_out;
  logic branch, busy;
  logic [4:0]  write_reg_out;
  logic [31:0] branch_addr, mem_addr, mem_write_data, reg_write_data;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  op_t  mon_o;

  always #5 clk = ~clk;

  exec_unit #(.XLEN(32), .REGW(5), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .reg1_data(reg1_data), .reg2_data(reg2_data),
    .alu_ctl(alu_ctl), .br_cond(br_cond), .branch_uc(branch_uc), .branch_c(branch_c),
    .branch_relative(branch_relative), .alu_pc(alu_pc), .alu_src(alu_src),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .writef_in(writef_in), .write_reg_in(write_reg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .writef_out(writef_out), .write_reg_out(write_reg_out),
    .branch(branch), .branch_addr(branch_addr), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .reg_write_data(reg_write_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] m_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      ALU_MUL:   return 32'(a * b);
      default:   return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] a, b, r;
    logic c;
    a = o.apc  ? o.pc  : o.r1;
    b = o.asrc ? o.imm : o.r2;
    r = m_alu(o.ctl, a, b);
    case (o.cond)
      BR_EQ:   c = (o.r1 == o.r2);
      BR_NE:   c = (o.r1 != o.r2);
      BR_LT:   c = ($signed(o.r1) < $signed(o.r2));
      BR_GE:   c = ($signed(o.r1) >= $signed(o.r2));
      BR_LTU:  c = (o.r1 < o.r2);
      BR_GEU:  c = (o.r1 >= o.r2);
      default: c = 1'b0;
    endcase
    e.branch = o.buc || (o.bc && c);
    if (o.brel && o.buc) e.baddr = o.pc + r;
    else if (o.brel)     e.baddr = o.pc + o.imm;
    else                 e.baddr = r & 32'hFFFF_FFFE;
    e.maddr = r;
    e.mwd   = o.r2;
    e.rwd   = o.buc ? o.pc + 32'd4 : r;
    e.mr = o.mr; e.mw = o.mw; e.rw = o.rw; e.wf = o.wf; e.wreg = o.wreg;
    return e;
  endfunction

  function automatic op_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o = '0;
    o.ctl = c; o.r1 = a; o.r2 = b; o.pc = 32'h100; o.rw = 1'b1; o.wreg = 5'd7;
    return o;
  endfunction

  task automatic apply(input op_t o);
    pc = o.pc; imm = o.imm; reg1_data = o.r1; reg2_data = o.r2;
    alu_ctl = o.ctl; br_cond = o.cond;
    branch_uc = o.buc; branch_c = o.bc; branch_relative = o.brel;
    alu_pc = o.apc; alu_src = o.asrc;
    mem_read_in = o.mr; mem_write_in = o.mw; reg_write_in = o.rw; writef_in = o.wf;
    write_reg_in = o.wreg;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic issue(input op_t o);
    bit ok;
    ok = 0;
    apply(o);
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Scoreboard: every cycle with out_valid is checked against the oldest accepted op.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          mon_e = exp_q[0];
          chk("branch",         {31'b0, branch},        {31'b0, mon_e.branch});
          chk("branch_addr",    branch_addr,            mon_e.baddr);
          chk("mem_addr",       mem_addr,               mon_e.maddr);
          chk("mem_write_data", mem_write_data,         mon_e.mwd);
          chk("reg_write_data", reg_write_data,         mon_e.rwd);
          chk("ctrl",           {27'b0, mem_read_out, mem_write_out, reg_write_out, writef_out, 1'b0},
                                {27'b0, mon_e.mr, mon_e.mw, mon_e.rw, mon_e.wf, 1'b0});
          chk("write_reg",      {27'b0, write_reg_out}, {27'b0, mon_e.wreg});
          $display("retire rwd=%h maddr=%h baddr=%h br=%0b", reg_write_data, mem_addr, branch_addr, branch);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mon_o.pc = pc; mon_o.imm = imm; mon_o.r1 = reg1_data; mon_o.r2 = reg2_data;
        mon_o.ctl = alu_ctl; mon_o.cond = br_cond;
        mon_o.buc = branch_uc; mon_o.bc = branch_c; mon_o.brel = branch_relative;
        mon_o.apc = alu_pc; mon_o.asrc = alu_src;
        mon_o.mr = mem_read_in; mon_o.mw = mem_write_in; mon_o.rw = reg_write_in;
        mon_o.wf = writef_in; mon_o.wreg = write_reg_in;
        exp_q.push_back(model(mon_o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    exp_t e;
    op_t tbl[$];

    // Literal pins on the model itself
    e = model(mk(ALU_ADD, 5, 7));                 chk("pin_add", e.rwd, 32'd12);
    o = mk(ALU_ADD, 32'hFFFF_FFFF, 1); o.bc = 1; o.cond = BR_LT;
    e = model(o);                                 chk("pin_lt", {31'b0, e.branch}, 32'd1);
    o.cond = BR_LTU; e = model(o);                chk("pin_ltu", {31'b0, e.branch}, 32'd0);
    e = model(mk(ALU_MUL, 7, 32'hFFFF_FFFD));     chk("pin_mul", e.rwd, 32'hFFFF_FFEB);
    o = mk(ALU_ADD, 32'h1000, 0); o.asrc = 1; o.imm = 1; o.buc = 1;
    e = model(o);                                 chk("pin_jump", e.baddr, 32'h1000);

    // Reset state
    #12;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_rwd",       reg_write_data,     32'd0);
    chk("rst_wreg",      {27'b0, write_reg_out}, 32'd0);
    step(); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    // ADD 5+7
    issue(mk(ALU_ADD, 5, 7));
    @(negedge clk);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_rwd",   reg_write_data, 32'd12);
    chk("add_maddr", mem_addr, 32'd12);
    step();

    // Compare set on 0xFFFFFFFF vs 1
    o = mk(ALU_ADD, 32'hFFFF_FFFF, 1); o.bc = 1;
    o.cond = BR_LT;  issue(o); @(negedge clk); chk("br_lt",  {31'b0, branch}, 32'd1); step();
    o.cond = BR_LTU; issue(o); @(negedge clk); chk("br_ltu", {31'b0, branch}, 32'd0); step();
    o.cond = BR_GEU; issue(o); @(negedge clk); chk("br_geu", {31'b0, branch}, 32'd1); step();
    o.cond = BR_GE;  issue(o); @(negedge clk); chk("br_ge",  {31'b0, branch}, 32'd0); step();
    o = mk(ALU_ADD, 32'h1000, 0); o.asrc = 1; o.imm = 1; o.buc = 1; o.pc = 32'h200;
    issue(o); @(negedge clk);
    chk("jmp_addr", branch_addr, 32'h1000);
    chk("jmp_link", reg_write_data, 32'h204);
    step();

    // Assorted single-cycle ops (scoreboard-checked)
    tbl.push_back(mk(ALU_SUB,  5, 7));
    tbl.push_back(mk(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00));
    tbl.push_back(mk(ALU_OR,   32'hF000_0000, 32'h0000_000F));
    tbl.push_back(mk(ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000));
    tbl.push_back(mk(ALU_SLL,  32'h0000_0003, 32'd31));
    tbl.push_back(mk(ALU_SRL,  32'h8000_0000, 32'd4));
    tbl.push_back(mk(ALU_SRA,  32'h8000_0000, 32'd4));
    tbl.push_back(mk(ALU_SLT,  32'hFFFF_FFFE, 32'd1));
    tbl.push_back(mk(ALU_SLTU, 32'hFFFF_FFFE, 32'd1));
    o = mk(ALU_PASSB, 1, 2); o.asrc = 1; o.imm = 32'hDEAD_0000; tbl.push_back(o);
    o = mk(ALU_ADD, 32'h10, 32'h20); o.apc = 1; o.pc = 32'h300; o.asrc = 1; o.imm = 32'h40;
    tbl.push_back(o);
    o = mk(ALU_ADD, 3, 3); o.bc = 1; o.cond = BR_EQ; o.brel = 1; o.imm = 32'h80; o.pc = 32'h400;
    o.mr = 1; o.mw = 1; o.wf = 1; o.wreg = 5'd31; tbl.push_back(o);
    o.cond = BR_NE; tbl.push_back(o);
    o = mk(ALU_ADD, 32'h10, 0); o.buc = 1; o.brel = 1; o.pc = 32'h500; o.asrc = 1; o.imm = 32'h20;
    tbl.push_back(o);
    foreach (tbl[i]) issue(tbl[i]);
    step();

    // Multiply with operands changed after accept
    issue(mk(ALU_MUL, 7, 32'hFFFF_FFFD));
    reg1_data = 32'h1234_5678; reg2_data = 32'h9;
    @(negedge clk);
    chk("mul_busy_c0",  {31'b0, busy},     32'd0);
    chk("mul_ready_c0", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("mul_busy",  {31'b0, busy},      32'd1);
      chk("mul_ready", {31'b0, in_ready},  32'd0);
      chk("mul_early", {31'b0, out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_done_busy",  {31'b0, busy},      32'd0);
    chk("mul_result",     reg_write_data,     32'hFFFF_FFEB);
    step();

    // Backpressure then back-to-back drain
    out_ready = 1'b0;
    issue(mk(ALU_ADD, 100, 23));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ready", {31'b0, in_ready},  32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_rwd",   reg_write_data,     32'd123);
    end
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(mk(ALU_SUB, 32'd1000 + k, 32'd11 + k));
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", {31'b0, in_ready},  32'd1);
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Flush during the 10th busy cycle
    issue(mk(ALU_MUL, 3, 5));
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",  {31'b0, busy},      32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready},  32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("flush_no_product", {31'b0, out_valid}, 32'd0);
    end
    step();

    // Asynchronous reset in the middle of a multiply
    issue(mk(ALU_MUL, 9, 9));
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  {31'b0, busy},      32'd0);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_rwd",   reg_write_data,     32'd0);
    chk("arst_maddr", mem_addr,           32'd0);
    chk("arst_mwd",   mem_write_data,     32'd0);
    chk("arst_baddr", branch_addr,        32'd0);
    chk("arst_ctrl",  {27'b0, write_reg_out, 1'b0} | {31'b0, reg_write_out}, 32'd0);
    step(); rst = 1'b0;
    step();
    issue(mk(ALU_ADD, 1, 2));
    @(negedge clk);
    chk("recover_rwd", reg_write_data, 32'd3);
    step(); step(); step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
